// File: rtl/scm_port_arbiter.sv
// Round-robin arbiter sharing a 3-read/2-write byte-enabled latch SCM among NUM_REQ requesters.
// Optional stall counter and write-conflict trace enabled by defining SCM_ARB_PERF_EN.
module scm_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_REQ*NUM_BYTE-1:0]    be_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             r_valid_o,
  output logic [DATA_WIDTH*NUM_REQ-1:0]  r_rdata_o,
  output logic [2:0]                     scm_re_o,
  output logic [3*ADDR_WIDTH-1:0]        scm_raddr_o,
  input  logic [3*DATA_WIDTH-1:0]        scm_rdata_i,
  output logic [1:0]                     scm_we_o,
  output logic [2*ADDR_WIDTH-1:0]        scm_waddr_o,
  output logic [2*DATA_WIDTH-1:0]        scm_wdata_o,
  output logic [2*NUM_BYTE-1:0]          scm_wbe_o,
  output logic [31:0]                    stall_cnt_o
);

  localparam int RR_W = $clog2(NUM_REQ);

  logic [RR_W-1:0]            rr_q, rr_d;
  logic [2:0][RR_W-1:0]       rsel_q, rsel_d;
  logic [2:0]                 rvld_q, rvld_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= '0;
      rvld_q <= '0;
      rsel_q <= '0;
    end else begin
      rr_q   <= rr_d;
      rvld_q <= rvld_d;
      rsel_q <= rsel_d;
    end
  end

  // Port usage fills in order, so the next free port is simply the count taken so far.
  always_comb begin
    gnt_o       = '0;
    scm_re_o    = '0;
    scm_raddr_o = '0;
    scm_we_o    = '0;
    scm_waddr_o = '0;
    scm_wdata_o = '0;
    scm_wbe_o   = '0;
    rsel_d      = rsel_q;
    rvld_d      = '0;
    rr_d        = rr_q;
    for (int i = 0, n_rd = 0, n_wr = 0; i < NUM_REQ; i++) begin
      int                    k;
      logic [ADDR_WIDTH-1:0] a;
      logic                  hit_w;
      logic                  hit_r;
      k = int'(rr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      a     = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      hit_w = 1'b0;
      hit_r = 1'b0;
      for (int p = 0; p < 2; p++)
        if (scm_we_o[p] && scm_waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] == a) hit_w = 1'b1;
      for (int p = 0; p < 3; p++)
        if (scm_re_o[p] && scm_raddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] == a) hit_r = 1'b1;
      if (!rst && req_i[k]) begin
        if (we_i[k]) begin
          if (n_wr < 2 && !hit_w && !hit_r) begin
            scm_we_o[n_wr]                             = 1'b1;
            scm_waddr_o[n_wr*ADDR_WIDTH +: ADDR_WIDTH] = a;
            scm_wdata_o[n_wr*DATA_WIDTH +: DATA_WIDTH] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            scm_wbe_o[n_wr*NUM_BYTE +: NUM_BYTE]       = be_i[k*NUM_BYTE +: NUM_BYTE];
            gnt_o[k] = 1'b1;
            rr_d     = (k == NUM_REQ - 1) ? '0 : RR_W'(k + 1);
            n_wr     = n_wr + 1;
          end
        end else begin
          if (n_rd < 3 && !hit_w) begin
            scm_re_o[n_rd]                             = 1'b1;
            scm_raddr_o[n_rd*ADDR_WIDTH +: ADDR_WIDTH] = a;
            rsel_d[n_rd] = RR_W'(k);
            rvld_d[n_rd] = 1'b1;
            gnt_o[k]     = 1'b1;
            rr_d         = (k == NUM_REQ - 1) ? '0 : RR_W'(k + 1);
            n_rd         = n_rd + 1;
          end
        end
      end
    end
  end

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    if (!rst) begin
      for (int p = 0; p < 3; p++) begin
        if (rvld_q[p]) begin
          r_valid_o[rsel_q[p]] = 1'b1;
          r_rdata_o[int'(rsel_q[p])*DATA_WIDTH +: DATA_WIDTH] = scm_rdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef SCM_ARB_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (|(req_i & ~gnt_o) && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++)
        for (int p = 0; p < 2; p++)
          if (req_i[k] && we_i[k] && !gnt_o[k] && scm_we_o[p] &&
              scm_waddr_o[p*ADDR_WIDTH +: ADDR_WIDTH] == addr_i[k*ADDR_WIDTH +: ADDR_WIDTH])
            $display("scm_port_arbiter: write conflict req %0d addr %0h at %0t",
                     k, addr_i[k*ADDR_WIDTH +: ADDR_WIDTH], $time);
    end
  end
`endif
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Self-checking bench for scm_port_arbiter with a behavioural SCM and a read-return scoreboard.
module tb_scm_port_arbiter;
  localparam int N = 4, AW = 5, DW = 32, NB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    req, we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*NB-1:0] be;
  logic [N-1:0]    gnt_o, r_valid_o;
  logic [N*DW-1:0] r_rdata_o;
  logic [2:0]      scm_re_o;
  logic [3*AW-1:0] scm_raddr_o;
  logic [3*DW-1:0] scm_rdata;
  logic [1:0]      scm_we_o;
  logic [2*AW-1:0] scm_waddr_o;
  logic [2*DW-1:0] scm_wdata_o;
  logic [2*NB-1:0] scm_wbe_o;
  logic [31:0]     stall_cnt_o;

  scm_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_o), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .scm_re_o(scm_re_o), .scm_raddr_o(scm_raddr_o), .scm_rdata_i(scm_rdata),
    .scm_we_o(scm_we_o), .scm_waddr_o(scm_waddr_o), .scm_wdata_o(scm_wdata_o),
    .scm_wbe_o(scm_wbe_o), .stall_cnt_o(stall_cnt_o)
  );

  function automatic logic [31:0] pat(int a);
    return 32'hA5A5_0000 + 32'(a);
  endfunction

  // SCM model: registered reads, byte-enabled writes, preloaded while reset is held.
  logic [DW-1:0] mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 32; a++) mem[a] <= pat(a);
    end else begin
      for (int p = 0; p < 3; p++)
        if (scm_re_o[p]) scm_rdata[p*DW +: DW] <= mem[scm_raddr_o[p*AW +: AW]];
      for (int w = 0; w < 2; w++)
        if (scm_we_o[w])
          for (int b = 0; b < NB; b++)
            if (scm_wbe_o[w*NB + b])
              mem[scm_waddr_o[w*AW +: AW]][b*8 +: 8] <= scm_wdata_o[w*DW + b*8 +: 8];
    end
  end

  typedef struct { int idx; logic [DW-1:0] data; } rd_t;
  rd_t exp_q[$];
  logic [DW-1:0] exp_d [N];
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_req(input int k, input logic w, input int a, input logic [31:0] d,
                         input logic [3:0] b);
    req[k] = 1'b1;
    we[k]  = w;
    addr[k*AW +: AW]  = AW'(a);
    wdata[k*DW +: DW] = w ? d : '0;
    be[k*NB +: NB]    = b;
    exp_d[k]          = w ? '0 : d;
  endtask

  task automatic clr(input int k);
    req[k] = 1'b0; we[k] = 1'b0;
    addr[k*AW +: AW] = '0; wdata[k*DW +: DW] = '0; be[k*NB +: NB] = '0;
  endtask

  // Called right after the drive point; samples at the falling edge.
  task automatic sample(input string tag, input logic [3:0] exp_gnt);
    logic [N-1:0]    ev;
    logic [N*DW-1:0] ed;
    ev = '0;
    ed = '0;
    #4;
    while (exp_q.size() > 0) begin
      rd_t e;
      e = exp_q.pop_front();
      ev[e.idx] = 1'b1;
      ed[e.idx*DW +: DW] = e.data;
    end
    chk({tag, ".rvalid"}, 128'(r_valid_o), 128'(ev));
    chk({tag, ".rdata"}, 128'(r_rdata_o), 128'(ed));
    chk({tag, ".gnt"}, 128'(gnt_o), 128'(exp_gnt));
`ifndef SCM_ARB_PERF_EN
    chk({tag, ".stall"}, 128'(stall_cnt_o), 128'(0));
`endif
    for (int k = 0; k < N; k++)
      if (exp_gnt[k] && !we[k]) exp_q.push_back('{k, exp_d[k]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt [N];
    int wait_c [N];
    int max_wait;
    int ptr;
    logic [3:0] eg;
`ifdef SCM_ARB_PERF_EN
    logic [31:0] s0;
`endif

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    for (int k = 0; k < N; k++) set_req(k, 1'b0, k, pat(k), 4'h0);
    sample("rst0", 4'b0000);
    chk("rst0.re", 128'(scm_re_o), 128'(0));
    chk("rst0.we", 128'(scm_we_o), 128'(0));
    tick();
    sample("rst1", 4'b0000);
    chk("rst1.re", 128'(scm_re_o), 128'(0));
    tick();
    rst = 1'b0;

    // four reads, only three read ports
    for (int k = 0; k < N; k++) set_req(k, 1'b0, k + 1, pat(k + 1), 4'h0);
    sample("rd4", 4'b0111);
    chk("rd4.raddr", 128'(scm_raddr_o), 128'({5'd3, 5'd2, 5'd1}));
    chk("rd4.re", 128'(scm_re_o), 128'(3'b111));
`ifdef SCM_ARB_PERF_EN
    chk("rd4.stall0", 128'(stall_cnt_o), 128'(0));
`endif
    tick();
    clr(0); clr(1); clr(2);
    sample("rd4b", 4'b1000);
    tick();
    clr(3);
    sample("rd4c", 4'b0000);
    tick();

    // same-address write conflict, rr=0
`ifdef SCM_ARB_PERF_EN
    s0 = stall_cnt_o;
`endif
    set_req(0, 1'b1, 5, 32'h1111_1111, 4'hF);
    set_req(1, 1'b1, 5, 32'h2222_2222, 4'hF);
    sample("wconf", 4'b0001);
    chk("wconf.we", 128'(scm_we_o), 128'(2'b01));
    chk("wconf.waddr", 128'(scm_waddr_o), 128'({5'd0, 5'd5}));
    chk("wconf.wdata", 128'(scm_wdata_o), 128'({32'd0, 32'h1111_1111}));
    tick();
`ifdef SCM_ARB_PERF_EN
    chk("wconf.stall", 128'(stall_cnt_o), 128'(s0 + 32'd1));
`endif
    clr(0);
    sample("wconf2", 4'b0010);
    tick();
    clr(1);
    set_req(2, 1'b0, 5, 32'h2222_2222, 4'h0);
    sample("wconf_rd", 4'b0100);
    tick();
    clr(2);
    sample("wconf_ret", 4'b0000);
    tick();

    // read/write same address, rr=3 so req0's write is scanned first
    set_req(0, 1'b1, 7, 32'hDEAD_BEEF, 4'hF);
    set_req(1, 1'b0, 7, 32'hDEAD_BEEF, 4'h0);
    sample("rw", 4'b0001);
    chk("rw.re", 128'(scm_re_o), 128'(0));
    tick();
    clr(0);
    sample("rw2", 4'b0010);
    tick();
    clr(1);
    sample("rw_ret", 4'b0000);
    tick();

    // zero byte-enable write, then three same-address reads; rr=2
    set_req(0, 1'b1, 8, 32'hFFFF_FFFF, 4'h0);
    sample("be0", 4'b0001);
    chk("be0.wbe", 128'(scm_wbe_o), 128'(0));
    chk("be0.we", 128'(scm_we_o), 128'(2'b01));
    tick();
    for (int k = 0; k < 3; k++) set_req(k, 1'b0, 8, pat(8), 4'h0);
    sample("rd3same", 4'b0111);
    chk("rd3same.raddr", 128'(scm_raddr_o), 128'({5'd8, 5'd8, 5'd8}));
    tick();
    clr(0); clr(1); clr(2);
    sample("rd3same_ret", 4'b0000);
    tick();

    // fairness: rr=1, everyone writes a distinct address for 8 cycles
    for (int k = 0; k < N; k++) begin
      set_req(k, 1'b1, 16 + k, 32'(k), 4'hF);
      cnt[k] = 0;
      wait_c[k] = 0;
    end
    max_wait = 0;
    ptr = 1;
    for (int c = 0; c < 8; c++) begin
      eg = '0;
      eg[ptr] = 1'b1;
      eg[(ptr + 1) % N] = 1'b1;
      ptr = (ptr + 2) % N;
      sample("fair", eg);
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) begin
          cnt[k]++;
          wait_c[k] = 0;
        end else begin
          wait_c[k]++;
          if (wait_c[k] > max_wait) max_wait = wait_c[k];
        end
      end
      tick();
    end
    for (int k = 0; k < N; k++) begin
      chk($sformatf("fair.cnt%0d", k), 128'(cnt[k]), 128'(4));
      clr(k);
    end
    chk("fair.maxwait_le2", 128'(max_wait <= 2), 128'(1));
    sample("fair_idle", 4'b0000);
    tick();

    // reset while a read is in flight drops the return; rr=1
    set_req(1, 1'b0, 3, pat(3), 4'h0);
    sample("rstmid", 4'b0010);
    exp_q.delete();
    tick();
    clr(1);
    rst = 1'b1;
    sample("rstmid2", 4'b0000);
    chk("rstmid2.re", 128'(scm_re_o), 128'(0));
    tick();
    rst = 1'b0;
    sample("rstmid3", 4'b0000);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scm_port_arbiter.md
Name: scm_port_arbiter

Overview:
- Shares one 3-read/2-write byte-enabled latch SCM among NUM_REQ requesters using a req/gnt handshake.
- Each cycle the block maps up to 3 reads onto SCM read ports A/B/C and up to 2 writes onto write ports A/B, in round-robin priority order.
- It never issues two writes to the same address in one cycle, and never issues a read and a write to the same address in one cycle.
- It routes each read's data back to the owning requester one cycle after the grant.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 5, SCM word address width
DATA_WIDTH, 32, word width; multiple of 8
NUM_BYTE, DATA_WIDTH/8, byte enables per word

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset; synchronous, active-high
req_i  in  NUM_REQ  request per requester
we_i  in  NUM_REQ  1 = write, 0 = read
addr_i  in  NUM_REQ*ADDR_WIDTH  word address per requester
wdata_i  in  NUM_REQ*DATA_WIDTH  write data per requester
be_i  in  NUM_REQ*NUM_BYTE  byte enables per requester
gnt_o  out  NUM_REQ  grant, combinational, same cycle as req
r_valid_o  out  NUM_REQ  read data valid, one cycle after a read grant
r_rdata_o  out  DATA_WIDTH*NUM_REQ  read data per requester
scm_re_o  out  3  ReadEnable A/B/C
scm_raddr_o  out  3*ADDR_WIDTH  ReadAddr A/B/C
scm_rdata_i  in  3*DATA_WIDTH  ReadData A/B/C
scm_we_o  out  2  WriteEnable A/B
scm_waddr_o  out  2*ADDR_WIDTH  WriteAddr A/B
scm_wdata_o  out  2*DATA_WIDTH  WriteData A/B
scm_wbe_o  out  2*NUM_BYTE  WriteBE A/B
stall_cnt_o  out  32  stall counter (see Optional Feature)

Behaviour:
- State: rr_q (round-robin pointer, $clog2(NUM_REQ) bits); rsel_q[p] (owner index of read port p); rvld_q[p].
- Reset:
  - On clk edge with rst=1: rr_q=0, rvld_q=0.
  - While rst=1: gnt_o=0, scm_re_o=0, scm_we_o=0, r_valid_o=0.
- Scan: each cycle, walk requesters in order rr_q, rr_q+1, ... wrapping mod NUM_REQ. For each req_i[k]=1:
  - Write (we_i[k]=1): grant on the lowest free write port unless any of these holds:
    - both write ports are already taken;
    - addr equals the address of a write already granted this cycle;
    - addr equals the address of a read already granted this cycle.
  - Read (we_i[k]=0): grant on the lowest free read port (A, then B, then C) unless all 3 are taken or addr equals the address of a write already granted this cycle.
  - Same-address reads are allowed; two requesters may read the same address on different ports.
- Ungranted requesters see gnt_o=0 and must hold req/we/addr/wdata/be stable until granted.
- SCM drive: granted ports receive the requester's fields verbatim; unused ports have enable=0 and address/data/BE=0.
- A write with be_i=0 is still granted and occupies a write port; the SCM makes no change.
- Read return:
  - rsel_q[p] and rvld_q[p] are registered at the grant edge.
  - Next cycle: r_valid_o[rsel_q[p]]=1 and r_rdata_o[rsel_q[p]]=scm_rdata_i[p].
  - Non-valid r_rdata_o slices are 0.
  - Read latency is exactly 1 cycle after gnt.
- Read-after-write: a write granted in cycle t is visible to a read granted in cycle t+1 or later. No forwarding logic is needed.
- rr_q update: if any grant is given, rr_q <= (index of the last requester granted in scan order + 1) mod NUM_REQ. Otherwise rr_q holds.
- Starvation freedom: any requester holding req is granted within NUM_REQ cycles.
- Reset mid-operation: pending r_valid_o is dropped and the in-flight read is lost. Requesters must reissue.

Optional Feature:
- Macro: SCM_ARB_PERF_EN.
- Defined:
  - stall_cnt_o is a 32-bit counter, cleared by rst.
  - It increments by 1 on each cycle where any req_i[k]=1 and gnt_o[k]=0, and saturates at 0xFFFFFFFF.
  - In non-synthesis builds, the block also $display's each same-address write conflict with address and $time.
- Undefined: stall_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- Reset: rst=1 for 2 cycles with all req=1 -> gnt_o=0, scm_re_o=0, scm_we_o=0; after release rr_q=0, so req0 is scanned first.
- 4 reads, NUM_REQ=4, rr_q=0, addrs 1,2,3,4 -> gnt=4'b0111, scm_raddr A/B/C=1/2/3; next cycle r_valid_o=4'b0111 with the matching data. req3 is granted the following cycle (rr_q=3).
- Write conflict: req0 and req1 both write addr 5 -> only req0 granted on write port A. Next cycle req1 is granted; a later read of addr 5 returns req1's data.
- Read/write same address: req0 writes 0xDEADBEEF to addr 7, be=4'hF, while req1 reads addr 7 -> req1 stalls. req1 is granted next cycle and its r_rdata_o equals 0xDEADBEEF one cycle later.
- Fairness: all 4 requesters write distinct addresses continuously for 8 cycles -> 2 writes granted per cycle, each requester granted exactly 4 times, no requester waits more than 2 cycles.
- With SCM_ARB_PERF_EN defined, in the conflict scenario above -> stall_cnt_o=1 after that cycle.
